// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM encoding, stage indices and saturating helper shared by pipe_ctrl and its perf counters
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_RUN = 2'd0, ST_STALL = 2'd1, ST_FLUSH = 2'd2;
  localparam int STG_IF = 0, STG_ID = 1, STG_EX = 2, STG_MEM = 3, STG_WB = 4;
  localparam int DEF_STAGES = STG_WB - STG_IF + 1;
  localparam int STALL_BUS_W = DEF_STAGES + 1;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating stall-cycle and flush counters, built only with PIPE_CTRL_PERF_EN
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall_any,
  input  logic        i_flush,
  output logic [31:0] o_stall_cyc,
  output logic [31:0] o_flush_cnt
);
  logic [31:0] r_stall_cyc, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cyc <= i_stall_any ? sat_inc32(r_stall_cyc) : r_stall_cyc;
      r_flush_cnt <= i_flush ? sat_inc32(r_flush_cnt) : r_flush_cnt;
    end
  end
  assign o_stall_cyc = r_stall_cyc;
  assign o_flush_cnt = r_flush_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/bubble/flush controller with stall watchdog; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_STAGES,
  parameter int STALL_TMO  = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES:0]   stall,
  output logic [NUM_STAGES:0]   bubble,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  stall_timeout,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_flush_cnt
);
  localparam int CW = $clog2(STALL_TMO + 1);
  logic [1:0] r_state, w_next;
  logic [31:0] r_pc;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_tmo, w_flush, w_active;
  logic [NUM_STAGES-1:0] w_fill;
  logic [NUM_STAGES:0] w_stall;
  // w_fill[i] is set when any stage at or above i requests a stall
  always_comb begin
    w_fill = '0;
    for (int i = 0; i < NUM_STAGES; i++) w_fill[i] = |(stallreq >> i);
  end
  assign w_flush  = !rst && r_state == ST_FLUSH;
  assign w_active = !rst && r_state != ST_FLUSH;
  assign w_stall  = w_active ? {w_fill, w_fill[0]} : '0;
  assign w_next   = flush_req ? ST_FLUSH : |stallreq ? ST_STALL : ST_RUN;
  assign w_cnt    = (r_cnt == CW'(STALL_TMO)) ? r_cnt : r_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= flush_req ? flush_pc : r_pc;
      r_cnt   <= (r_state == ST_STALL && w_next == ST_STALL) ? w_cnt : '0;
      r_tmo   <= r_tmo | (r_state == ST_STALL && w_cnt == CW'(STALL_TMO));
    end
  end
  assign stall          = w_stall;
  assign bubble         = {w_stall[NUM_STAGES-1:0] & ~w_stall[NUM_STAGES:1], 1'b0};
  assign flush          = w_flush;
  assign redirect_valid = w_flush;
  assign redirect_pc    = w_flush ? r_pc : '0;
  assign stall_timeout  = r_tmo;
`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_stall_any (w_stall[0]),
    .i_flush     (w_flush),
    .o_stall_cyc (perf_stall_cyc),
    .o_flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a cycle-level behavioural model of pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int N = DEF_STAGES;
  localparam int TMO = 7;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush_req = 1'b0;
  logic [N-1:0] stallreq = '0;
  logic [31:0] flush_pc = '0;
  logic [STALL_BUS_W-1:0] stall, bubble;
  logic flush, redirect_valid, stall_timeout;
  logic [31:0] redirect_pc, perf_stall_cyc, perf_flush_cnt;
  int n_chk = 0, n_err = 0;
  bit m_flush = 0, m_in_stall = 0, m_tmo = 0;
  int m_scnt = 0, m_pst = 0, m_pfl = 0;
  logic [31:0] m_pc = '0;

  pipe_ctrl #(.NUM_STAGES(N), .STALL_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .bubble(bubble), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_timeout(stall_timeout),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_req(input logic [N-1:0] sr);
    int k = -1;
    for (int i = 0; i < N; i++) if (sr[i]) k = i;
    return k;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] sr, input logic fr, input logic [31:0] pc);
    int k;
    logic [STALL_BUS_W-1:0] e_stall, e_bub;
    rst = r; stallreq = sr; flush_req = fr; flush_pc = pc;
    #2;
    k = top_req(sr);
    e_stall = (r || m_flush || k < 0) ? '0 : STALL_BUS_W'((1 << (k + 2)) - 1);
    e_bub = (r || m_flush || k < 0 || k + 2 > N) ? '0 : STALL_BUS_W'(1 << (k + 2));
    check("stall", 32'(stall), 32'(e_stall));
    check("bubble", 32'(bubble), 32'(e_bub));
    check("flush", 32'(flush), 32'(!r && m_flush));
    check("redirect_valid", 32'(redirect_valid), 32'(!r && m_flush));
    check("redirect_pc", redirect_pc, (!r && m_flush) ? m_pc : 32'd0);
    check("stall_timeout", 32'(stall_timeout), 32'(m_tmo));
    check("perf_stall_cyc", perf_stall_cyc, PERF ? 32'(m_pst) : 32'd0);
    check("perf_flush_cnt", perf_flush_cnt, PERF ? 32'(m_pfl) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_flush = 0; m_in_stall = 0; m_tmo = 0; m_scnt = 0; m_pst = 0; m_pfl = 0; m_pc = '0;
    end else begin
      if (e_stall != 0) m_pst++;
      if (m_flush) m_pfl++;
      if (m_in_stall) begin
        m_scnt++;
        if (m_scnt >= TMO) m_tmo = 1;
      end
      m_in_stall = !fr && sr != 0;
      if (!m_in_stall) m_scnt = 0;
      m_flush = fr;
      if (fr) m_pc = pc;
    end
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    step(1, '0, 0, 0);
    step(1, 5'b11111, 1, 32'h1234);
    step(0, '0, 0, 0);
    check("after_reset_stall", 32'(stall), 32'd0);
    step(0, 5'b00100, 0, 0);
    step(0, 5'b00110, 0, 0);
    step(0, 5'b10000, 0, 0);
    step(0, '0, 0, 0);
    step(0, 5'b00100, 1, 32'hBFC00380);
    check("flush_pc_seen", redirect_pc, 32'hBFC00380);
    step(0, 5'b00100, 0, 0);
    step(0, 5'b00100, 0, 0);
    step(0, '0, 1, 32'hA0000000);
    step(0, '0, 1, 32'hB0000004);
    step(0, 5'b00001, 0, 0);
    step(0, '0, 0, 0);
    step(1, '0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 5'b00100, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    check("timeout_sticky", 32'(stall_timeout), 32'd1);
    step(0, '0, 1, 32'h8000_0180);
    step(1, 5'b00010, 0, 0);
    step(0, '0, 0, 0);
    step(0, 5'b01000, 0, 0);
    step(1, 5'b01000, 0, 0);
    step(0, '0, 0, 0);
    step(1, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 5'b00001, 0, 0);
    step(0, '0, 1, 32'h100);
    step(0, '0, 0, 0);
    step(0, '0, 1, 32'h200);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("perf_stall_3", perf_stall_cyc, PERF ? 32'd3 : 32'd0);
    check("perf_flush_2", perf_flush_cnt, PERF ? 32'd2 : 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] sr;
      sr = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      step($urandom_range(0, 63) == 0, sr, $urandom_range(0, 7) == 0, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 5, number of pipeline stages (IF=0 .. WB=NUM_STAGES-1).
REQ-002 SHALL provide parameter STALL_TMO, default 1023, count of consecutive stall cycles that raises the timeout flag.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port stallreq  input  NUM_STAGES  bit i set = stage i requests a stall.
REQ-006 SHALL provide port flush_req  input  1  exception/eret commit; sampled on the clock edge.
REQ-007 SHALL provide port flush_pc  input  32  redirect target, valid when flush_req=1.
REQ-008 SHALL provide port stall  output  NUM_STAGES+1  bit 0 holds PC; bit j holds the register feeding stage j.
REQ-009 SHALL provide port bubble  output  NUM_STAGES+1  bit j set = register j loads a NOP this cycle.
REQ-010 SHALL provide port flush  output  1  clear all pipeline registers.
REQ-011 SHALL provide ports redirect_valid  output  1 and redirect_pc  output  32, the PC redirect.
REQ-012 SHALL provide port stall_timeout  output  1  sticky stall-watchdog flag.
REQ-013 SHALL provide ports perf_stall_cyc  output  32 and perf_flush_cnt  output  32, the performance counters.

Function
REQ-014 SHALL implement FSM states RUN, STALL, FLUSH.
REQ-015 In RUN/STALL, with k = highest index of set stallreq bits, stall bits 0..k+1 SHALL be 1, combinationally (zero latency); all-zero requests SHALL give stall=0.
REQ-016 bubble[k+2] SHALL be 1 when k+2<=NUM_STAGES; all other bubble bits SHALL be 0.
REQ-017 Transitions: RUN->STALL if any stallreq and no flush_req; STALL->RUN when stallreq=0; any state->FLUSH if flush_req=1.
REQ-018 flush_req SHALL take priority over stallreq in the same cycle.
REQ-019 flush_pc SHALL be registered when flush_req=1.
REQ-020 FLUSH SHALL last exactly one cycle, with flush=1, redirect_valid=1, redirect_pc=the registered flush_pc, stall=0, bubble=0, and stallreq ignored.
REQ-021 flush_req during FLUSH SHALL re-enter FLUSH with the new flush_pc (back-to-back); otherwise the next state SHALL be STALL or RUN per stallreq.
REQ-022 stall_cnt (width clog2(STALL_TMO+1)) SHALL count consecutive cycles in STALL, saturate at STALL_TMO, and clear on leaving STALL.
REQ-023 When stall_cnt reaches STALL_TMO, stall_timeout SHALL set; it SHALL remain set until rst.

Reset
REQ-024 While rst=1: state=RUN, stall=0, bubble=0, flush=0, redirect_valid=0, redirect_pc=0, stall_timeout=0, all counters=0.
REQ-025 Reset asserted mid-FLUSH or mid-STALL SHALL abort the operation; the cycle after rst deasserts SHALL start in RUN.

Configuration
REQ-026 Macro PIPE_CTRL_PERF_EN defined: perf_stall_cyc SHALL increment each cycle any stall bit is 1, and perf_flush_cnt on each FLUSH cycle; both saturate at 0xFFFFFFFF.
REQ-027 Macro undefined: both perf ports SHALL remain present and constant 0, with no counter flops.

Structure
REQ-028 FSM state encoding and the stage-index constants (IF..WB, StallBus width) SHALL live in the shared package pipe_ctrl_pkg.
REQ-029 The performance counters SHALL be sub-module pipe_ctrl_perf, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-030 rst=1 for 2 cycles -> all outputs 0 and state RUN; the first cycle after release shows stall=0.
REQ-031 NUM_STAGES=5, stallreq=5'b00100 -> same cycle stall=6'b001111, bubble=6'b010000.
REQ-032 stallreq=5'b00110, then 5'b10000 -> stall=6'b001111, then 6'b111111 with bubble=0.
REQ-033 flush_req=1, flush_pc=0xBFC00380, stallreq=5'b00100 in the same cycle -> next cycle flush=1, redirect_valid=1, redirect_pc=0xBFC00380, stall=0; the following cycle returns to STALL.
REQ-034 STALL_TMO=7, stallreq=5'b00100 held 10 cycles then 0 -> stall_timeout rises on the 7th stall cycle and stays 1 afterwards.
REQ-035 With PIPE_CTRL_PERF_EN: 3 stall cycles plus 2 flushes -> perf_stall_cyc=3, perf_flush_cnt=2; the same stimulus without the macro gives 0 and 0.
